fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder in the MIPS core.
- Holds the PC and fetches from instruction memory over a variable-latency req/ready handshake.
- Presents the current instruction and PC to the decoder, and computes the next PC from the decoder's jump/jr/branch outputs.
- Supports multi-cycle memory, so the PC advances only when downstream asserts `advance_i`.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset (word-aligned).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address (= pc_o while imem_req=1).
- imem_ready  in  1  read data valid this cycle; meaningful only while imem_req=1.
- imem_rdata  in  32  instruction word returned with imem_ready.
- instr_o  out  32  registered instruction presented to the decoder.
- pc_o  out  32  address of instr_o.
- pc_plus4_o  out  32  pc_o+4 (link value for JAL).
- instr_valid_o  out  1  instr_o/pc_o valid; the decoder's outputs are meaningful only when this is 1.
- advance_i  in  1  downstream has completed instr_o; commit next PC.
- jump_i, jr_i, beq_i, bne_i, blez_i, bgtz_i  in  1 each  decoder control outputs for instr_o.
- zero_i  in  1  ALU zero flag from the rs-rt subtract (BEQ/BNE).
- rs_data_i  in  32  register-file rs read value (JR target, BLEZ/BGTZ operand).

Behaviour:
- Reset (rst=1 at clock edge):
  - pc_o=RESET_PC, instr_o=0, instr_valid_o=0, imem_req=0, state=S_IDLE.
  - Overrides any transaction in progress; a response arriving in the reset cycle is discarded.
- States:
  - S_IDLE: imem_req=0 for exactly one cycle, then go to S_REQ. This guarantees no stale imem_ready is accepted.
  - S_REQ: imem_req=1, imem_addr=pc_o, instr_valid_o=0. On imem_ready=1: instr_o<=imem_rdata, go to S_VALID. Otherwise remain (unbounded wait).
  - S_VALID: imem_req=0, instr_valid_o=1. On advance_i=1: pc_o<=next_pc, go to S_REQ. Otherwise hold; instr_o and pc_o are stable.
- advance_i is ignored outside S_VALID. imem_ready is ignored outside S_REQ.
- Minimum instruction period is 2 cycles: zero-wait memory (ready in the first S_REQ cycle) plus advance_i in the first S_VALID cycle.
- next_pc is combinational, evaluated in S_VALID. Priority, highest first:
  1. jr_i: rs_data_i with bits [1:0] forced to 0.
  2. jump_i: {pc_plus4_o[31:28], instr_o[25:0], 2'b00}.
  3. Taken branch: pc_plus4_o + (sign_extend(instr_o[15:0]) << 2).
  4. Otherwise: pc_plus4_o.
- Branch-taken conditions:
  - beq_i & zero_i.
  - bne_i & ~zero_i.
  - blez_i & (rs_data_i[31] | rs_data_i==0).
  - bgtz_i & ~rs_data_i[31] & rs_data_i!=0.
  - More than one branch flag asserted: taken if any asserted condition holds.
- Arithmetic: all PC arithmetic is 32-bit modulo. 0xFFFF_FFFC+4 wraps to 0. Backward branches may underflow-wrap.
- No delay slot: the instruction at a taken target is the next one fetched.
- pc_plus4_o is combinational from pc_o and is valid in all states.

Test Plan:
- Reset then zero-wait memory, advance_i held 1, no controls → imem_addr sequence 0x3000, 0x3004, 0x3008; each instruction valid for one cycle, one instruction per 2 cycles.
- Memory with 3-cycle latency at 0x3000 → imem_req high 3 cycles, instr_valid_o rises the cycle after imem_ready, imem_rdata captured exactly.
- At pc 0x3010, instr_o[15:0]=0xFFFE, beq_i=1, zero_i=1 → next fetch 0x300C. Same with zero_i=0 → 0x3014. bne_i=1, zero_i=0, offset 0x0003 → 0x3020.
- At pc 0x3004, jump_i=1, instr_o[25:0]=0x0000C10 → 0x3040. jr_i=1 with jump_i=1, rs_data_i=0x0000_4007 → 0x4004 (jr wins, low bits cleared).
- blez_i=1 with rs_data_i=0, then 0xFFFF_FFFF, then 1 → taken, taken, not taken. bgtz_i=1 with the same values → not taken, not taken, taken.
- rst asserted mid-S_REQ with imem_ready=1 in the same cycle → data discarded, instr_valid_o=0, one S_IDLE cycle, refetch at RESET_PC.
- instr_valid_o=1 with advance_i held 0 for 5 cycles → pc_o and instr_o unchanged, imem_req=0 throughout.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a variable-latency req/ready
// handshake and resolves the next PC from the decoder's jump/jr/branch controls.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        instr_valid_o,
    input  logic        advance_i,
    input  logic        jump_i,
    input  logic        jr_i,
    input  logic        beq_i,
    input  logic        bne_i,
    input  logic        blez_i,
    input  logic        bgtz_i,
    input  logic        zero_i,
    input  logic [31:0] rs_data_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic signed [31:0] r_pc;
    logic signed [31:0] w_pc_nxt;
    logic        [31:0] r_instr;
    logic        [31:0] w_instr_nxt;
    logic signed [31:0] w_pc_plus4;
    logic signed [31:0] w_next_pc;
    logic               w_taken;

    // Word offset of a branch: sign-extended immediate scaled to bytes.
    function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic branch_taken(
        input logic        beq,
        input logic        bne,
        input logic        blez,
        input logic        bgtz,
        input logic        zero,
        input logic [31:0] rs
    );
        logic rs_zero;
        rs_zero = (rs == 32'd0);
        return (beq & zero) | (bne & ~zero) |
               (blez & (rs[31] | rs_zero)) |
               (bgtz & ~rs[31] & ~rs_zero);
    endfunction

    assign w_pc_plus4 = r_pc + 32'sd4;
    assign w_taken    = branch_taken(beq_i, bne_i, blez_i, bgtz_i, zero_i, rs_data_i);

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jr_i) begin
            w_next_pc = {rs_data_i[31:2], 2'b00};
        end else if (jump_i) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (w_taken) begin
            w_next_pc = w_pc_plus4 + branch_offset(r_instr[15:0]);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_instr_nxt   = r_instr;
        imem_req      = 1'b0;
        instr_valid_o = 1'b0;
        case (r_state)
            // One dead cycle so a stale ready from before reset is never taken.
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_instr_nxt = imem_rdata;
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                instr_valid_o = 1'b1;
                if (advance_i) begin
                    w_pc_nxt    = w_next_pc;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
        end
    end

    assign imem_addr  = r_pc;
    assign pc_o       = r_pc;
    assign pc_plus4_o = w_pc_plus4;
    assign instr_o    = r_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake timing sequences plus a table of
// next-PC vectors reached by steering the PC with a JR.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        instr_valid_o;
    logic        advance_i;
    logic        jump_i, jr_i, beq_i, bne_i, blez_i, bgtz_i, zero_i;
    logic [31:0] rs_data_i;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .instr_valid_o(instr_valid_o),
        .advance_i    (advance_i),
        .jump_i       (jump_i),
        .jr_i         (jr_i),
        .beq_i        (beq_i),
        .bne_i        (bne_i),
        .blez_i       (blez_i),
        .bgtz_i       (bgtz_i),
        .zero_i       (zero_i),
        .rs_data_i    (rs_data_i)
    );

    always #5 clk = ~clk;

    // ctl bits: {jr, jump, beq, bne, blez, bgtz}
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  ctl;
        logic        zero;
        logic [31:0] rs;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_ctl();
        {jr_i, jump_i, beq_i, bne_i, blez_i, bgtz_i} = 6'b0;
        zero_i    = 1'b0;
        rs_data_i = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{32'h0000_3010, 32'h1000_FFFE, 6'b001000, 1'b1, 32'd0,         32'h0000_300C};
        vecs[1]  = '{32'h0000_3010, 32'h1000_FFFE, 6'b001000, 1'b0, 32'd0,         32'h0000_3014};
        vecs[2]  = '{32'h0000_3010, 32'h1400_0003, 6'b000100, 1'b0, 32'd0,         32'h0000_3020};
        vecs[3]  = '{32'h0000_3004, 32'h0800_0C10, 6'b010000, 1'b0, 32'd0,         32'h0000_3040};
        vecs[4]  = '{32'h0000_3004, 32'h0800_0C10, 6'b110000, 1'b0, 32'h0000_4007, 32'h0000_4004};
        vecs[5]  = '{32'h0000_3000, 32'h1800_0010, 6'b000010, 1'b0, 32'h0000_0000, 32'h0000_3044};
        vecs[6]  = '{32'h0000_3000, 32'h1800_0010, 6'b000010, 1'b0, 32'hFFFF_FFFF, 32'h0000_3044};
        vecs[7]  = '{32'h0000_3000, 32'h1800_0010, 6'b000010, 1'b0, 32'h0000_0001, 32'h0000_3004};
        vecs[8]  = '{32'h0000_3000, 32'h1C00_0010, 6'b000001, 1'b0, 32'h0000_0000, 32'h0000_3004};
        vecs[9]  = '{32'h0000_3000, 32'h1C00_0010, 6'b000001, 1'b0, 32'hFFFF_FFFF, 32'h0000_3004};
        vecs[10] = '{32'h0000_3000, 32'h1C00_0010, 6'b000001, 1'b0, 32'h0000_0001, 32'h0000_3044};
        vecs[11] = '{32'hFFFF_FFFC, 32'h0000_0000, 6'b000000, 1'b0, 32'd0,         32'h0000_0000};
        vecs[12] = '{32'h0000_0000, 32'h1000_8000, 6'b001000, 1'b1, 32'd0,         32'hFFFE_0004};
        vecs[13] = '{32'h0000_3010, 32'h1000_0003, 6'b001100, 1'b0, 32'd0,         32'h0000_3020};
        vecs[14] = '{32'hA000_0000, 32'h0800_0001, 6'b010000, 1'b0, 32'd0,         32'hA000_0004};

        rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'd0; advance_i = 1'b0;
        clear_ctl();
        step(); step();
        chk("reset_pc", pc_o, 32'h0000_3000);
        chk("reset_instr", instr_o, 32'd0);
        chk("reset_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("reset_req", {31'd0, imem_req}, 32'd0);

        // Zero-wait memory with advance held: one instruction every two cycles.
        rst = 1'b0; imem_ready = 1'b1; advance_i = 1'b1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] exp_addr;
            exp_addr = 32'h0000_3000 + 32'(4 * (i / 2));
            step();
            chk($sformatf("zw_req_%0d", i), {31'd0, imem_req}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("zw_valid_%0d", i), {31'd0, instr_valid_o}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("zw_addr_%0d", i), imem_addr, exp_addr);
        end

        // Three-cycle memory latency, then a five-cycle hold with advance low.
        advance_i = 1'b0; imem_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        imem_rdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lat_req_%0d", i), {31'd0, imem_req}, 32'd1);
            chk($sformatf("lat_valid_%0d", i), {31'd0, instr_valid_o}, 32'd0);
            chk($sformatf("lat_addr_%0d", i), imem_addr, 32'h0000_3000);
            if (i == 2) imem_ready = 1'b1;
            step();
        end
        imem_ready = 1'b0;
        chk("lat_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("lat_instr", instr_o, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            imem_ready = 1'b1; imem_rdata = 32'hBAD0_0000 + 32'(i);
            step();
            chk($sformatf("hold_pc_%0d", i), pc_o, 32'h0000_3000);
            chk($sformatf("hold_instr_%0d", i), instr_o, 32'h1234_5678);
            chk($sformatf("hold_req_%0d", i), {31'd0, imem_req}, 32'd0);
            chk($sformatf("hold_valid_%0d", i), {31'd0, instr_valid_o}, 32'd1);
        end
        imem_ready = 1'b0;

        // Next-PC table: steer PC with JR, load the instruction, then advance.
        for (int v = 0; v < 15; v++) begin
            jr_i = 1'b1; rs_data_i = vecs[v].pc; advance_i = 1'b1;
            step();
            clear_ctl(); advance_i = 1'b0;
            imem_rdata = vecs[v].instr; imem_ready = 1'b1;
            step();
            imem_ready = 1'b0;
            chk($sformatf("vec%0d_pc", v), pc_o, vecs[v].pc);
            chk($sformatf("vec%0d_pc4", v), pc_plus4_o, vecs[v].pc + 32'd4);
            {jr_i, jump_i, beq_i, bne_i, blez_i, bgtz_i} = vecs[v].ctl;
            zero_i = vecs[v].zero; rs_data_i = vecs[v].rs; advance_i = 1'b1;
            step();
            clear_ctl(); advance_i = 1'b0;
            chk($sformatf("vec%0d_next", v), imem_addr, vecs[v].exp_next);
            chk($sformatf("vec%0d_req", v), {31'd0, imem_req}, 32'd1);
            imem_rdata = 32'd0; imem_ready = 1'b1;
            step();
            imem_ready = 1'b0;
        end

        // Reset in S_REQ while memory responds: response must be dropped.
        advance_i = 1'b1;
        step();
        advance_i = 1'b0;
        chk("rr_in_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        rst = 1'b0;
        chk("rr_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rr_req_idle", {31'd0, imem_req}, 32'd0);
        chk("rr_instr", instr_o, 32'd0);
        chk("rr_pc", pc_o, 32'h0000_3000);
        step();
        chk("rr_refetch_req", {31'd0, imem_req}, 32'd1);
        chk("rr_refetch_addr", imem_addr, 32'h0000_3000);
        imem_rdata = 32'h0000_0042;
        step();
        imem_ready = 1'b0;
        chk("rr_refetch_instr", instr_o, 32'h0000_0042);
        chk("rr_refetch_valid", {31'd0, instr_valid_o}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
